// File: rtl/dds_pkg.sv
// Shared DDS definitions: wave selects, sample widths and stage bundles.
// The quarter-wave sine table is built here at elaboration time.
package dds_pkg;

  localparam int IDX_W  = 11;
  localparam int DATA_W = 10;
  localparam int AMP_W  = 9;
  localparam int S_W    = 10;
  localparam int ROM_AW = 9;

  localparam logic [DATA_W-1:0] MIDSCALE  = 10'd512;
  localparam logic [AMP_W-1:0]  AMP_UNITY = 9'd256;
  localparam logic [S_W-1:0]    FULL_POS  = 10'd511;
  localparam logic [S_W-1:0]    NEG_FULL  = 10'h201;
  localparam logic [S_W-1:0]    NEG_CLIP  = 10'h200;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_e;

  typedef struct packed {
    logic             v;
    logic [IDX_W-1:0] idx;
    wave_e            sel;
    logic [AMP_W-1:0] amp;
  } s0_t;

  typedef struct packed {
    logic             v;
    logic             neg;
    wave_e            sel;
    logic [AMP_W-1:0] amp;
    logic [S_W-1:0]   s;
  } s1_t;

  typedef struct packed {
    logic             v;
    logic [AMP_W-1:0] amp;
    logic [S_W-1:0]   s;
  } s2_t;

  // Unsigned 0..1023 ramp to bipolar, pulling -512 in to keep +/-511 symmetry.
  function automatic logic [S_W-1:0] to_bipolar(
    input logic [S_W-1:0] u
  );
    logic [S_W-1:0] b;
    b = u - MIDSCALE;
    if (b == NEG_CLIP) b = NEG_FULL;
    return b;
  endfunction

  localparam longint PI_Q30 = 64'sd3373259426;

  // round(511*sin(pi*(2i+1)/2048)) via Q30 Taylor series.
  function automatic logic [8:0] quarter_sine(input int i);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint v;
    x    = (PI_Q30 * longint'(2 * i + 1)) / 64'sd2048;
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int k = 1; k <= 10; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    v = (64'sd511 * sum + 64'sd536870912) >>> 30;
    return 9'(v);
  endfunction

  function automatic logic [511:0][8:0] quarter_sine_table();
    logic [511:0][8:0] t;
    for (int i = 0; i < 512; i++) t[i] = quarter_sine(i);
    return t;
  endfunction

endpackage

// File: rtl/dds_quarter_sine_rom.sv
// Registered-read 512x9 quarter-wave sine magnitude table.
// Contents are fixed at elaboration; no reset on the data path.
module dds_quarter_sine_rom
  import dds_pkg::*;
(
  input  logic       clk,
  input  logic [8:0] addr,
  output logic [8:0] data
);

  localparam logic [511:0][8:0] TABLE = quarter_sine_table();

  always_ff @(posedge clk) begin
    data <= TABLE[addr];
  end

endmodule

// File: rtl/dds_wave_shaper.sv
// Phase-to-amplitude stage: index/offset, shape, sine lookup, scaling.
// Four register stages, each with its own valid; no backpressure.
module dds_wave_shaper #(
  parameter int PHASE_W = 32,
  parameter int IDX_W   = 11,
  parameter int DATA_W  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [PHASE_W-1:0] in_phase,
  input  logic [IDX_W-1:0]   phase_off,
  input  logic [1:0]         wave_sel,
  input  logic [8:0]         amp,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_sample
);
  import dds_pkg::*;

  s0_t s0_q, s0_d;
  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_sample_q, out_sample_d;

  logic [8:0]        rom_addr;
  logic [8:0]        mag;
  logic [S_W-1:0]    ramp;
  logic [S_W-1:0]    shp;
  logic [19:0]       s_ext, a_ext;
  logic signed [19:0] prod;
  logic [S_W-1:0]    scaled;
  logic              unused_ok;

  always_comb begin
    s0_d.v   = in_valid;
    s0_d.idx = in_phase[PHASE_W-1 -: IDX_W] + phase_off;
    s0_d.sel = wave_e'(wave_sel);
    s0_d.amp = (amp > AMP_UNITY) ? AMP_UNITY : amp;
  end

  always_comb begin
    rom_addr = s0_q.idx[9] ? ~s0_q.idx[8:0] : s0_q.idx[8:0];
    ramp     = s0_q.idx[10] ? ~s0_q.idx[9:0] : s0_q.idx[9:0];
    shp      = '0;
    unique case (1'b1)
      (s0_q.sel == WAVE_SQUARE):
        shp = s0_q.idx[10] ? NEG_FULL : FULL_POS;
      (s0_q.sel == WAVE_TRI):
        shp = to_bipolar(ramp);
      (s0_q.sel == WAVE_SAW):
        shp = to_bipolar(s0_q.idx[10:1]);
      (s0_q.sel == WAVE_SINE):
        shp = '0;
    endcase
    s1_d.v   = s0_q.v;
    s1_d.neg = s0_q.idx[10];
    s1_d.sel = s0_q.sel;
    s1_d.amp = s0_q.amp;
    s1_d.s   = shp;
  end

  dds_quarter_sine_rom u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (mag)
  );

  always_comb begin
    s2_d.v   = s1_q.v;
    s2_d.amp = s1_q.amp;
    s2_d.s   = s1_q.s;
    if (s1_q.sel == WAVE_SINE) begin
      s2_d.s = s1_q.neg ? -{1'b0, mag} : {1'b0, mag};
    end
  end

  // Arithmetic shift of the product floors toward -inf.
  always_comb begin
    s_ext  = {{10{s2_q.s[S_W-1]}}, s2_q.s};
    a_ext  = {11'd0, s2_q.amp};
    prod   = $signed(s_ext) * $signed(a_ext);
    scaled = prod[17:8];
    out_sample_d = out_sample_q;
    if (s2_q.v) out_sample_d = scaled + MIDSCALE;
  end

  assign unused_ok = ^{prod[19:18], prod[7:0],
                       in_phase[PHASE_W-IDX_W-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q         <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      out_valid_q  <= 1'b0;
      out_sample_q <= MIDSCALE;
    end else begin
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      out_valid_q  <= s2_q.v;
      out_sample_q <= out_sample_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;

endmodule

// File: tb/tb_dds_wave_shaper.sv
// Bench for dds_wave_shaper: vector table, bursts, mid-stream reset,
// and a random stream checked against a real-math reference model.
module tb_dds_wave_shaper;

  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_phase = '0;
  logic [10:0] phase_off = '0;
  logic [1:0]  wave_sel = '0;
  logic [8:0]  amp = '0;
  logic        out_valid;
  logic [9:0]  out_sample;

  int n_cmp = 0;
  int n_bad = 0;

  dds_wave_shaper dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_phase   (in_phase),
    .phase_off  (phase_off),
    .wave_sel   (wave_sel),
    .amp        (amp),
    .out_valid  (out_valid),
    .out_sample (out_sample)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ph;
    logic [10:0] off;
    logic [1:0]  sel;
    logic [8:0]  amp;
    int          exp;
    string       name;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, wanted %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int ref_sample(input logic [31:0] ph,
                                    input logic [10:0] off,
                                    input logic [1:0] sel,
                                    input logic [8:0] a_in);
    int  idx;
    int  a;
    int  s;
    int  t;
    real r;
    idx = (int'(ph >> 21) + int'(off)) % 2048;
    a   = (a_in > 9'd256) ? 256 : int'(a_in);
    case (sel)
      2'd0: begin
        r = 511.0 * $sin(PI * real'(2 * idx + 1) / 2048.0);
        s = (r < 0.0) ? -$rtoi(0.5 - r) : $rtoi(r + 0.5);
      end
      2'd1: s = (idx >= 1024) ? -511 : 511;
      2'd2: begin
        t = (idx >= 1024) ? 2047 - idx : idx;
        s = t - 512;
      end
      default: s = idx / 2 - 512;
    endcase
    if (s < -511) s = -511;
    return $rtoi($floor(real'(s * a) / 256.0)) + 512;
  endfunction

  // Reference: per-edge expectation slots, due 3 edges after acceptance.
  bit exp_v[64];
  int exp_s[64];
  int held = 512;
  int ecnt = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) exp_v[i] = 1'b0;
      held = 512;
    end else begin
      ecnt++;
      exp_v[(ecnt + 3) % 64] = in_valid;
      if (in_valid)
        exp_s[(ecnt + 3) % 64] = ref_sample(in_phase, phase_off, wave_sel, amp);
    end
  end

  always @(negedge clk) begin
    int k;
    if (!rst_n) begin
      check("rst_valid", int'(out_valid), 0);
      check("rst_sample", int'(out_sample), 512);
    end else begin
      k = ecnt % 64;
      check("model_valid", int'(out_valid), int'(exp_v[k]));
      if (exp_v[k]) held = exp_s[k];
      check("model_sample", int'(out_sample), held);
    end
  end

  task automatic drive(input bit v, input vec_t x);
    in_valid  = v;
    in_phase  = x.ph;
    phase_off = x.off;
    wave_sel  = x.sel;
    amp       = x.amp;
  endtask

  task automatic run_vec(input vec_t x);
    int lat;
    bit seen;
    @(negedge clk);
    drive(1'b1, x);
    @(negedge clk);
    in_valid  = 1'b0;
    in_phase  = $urandom();
    phase_off = 11'($urandom_range(0, 2047));
    wave_sel  = ~x.sel;
    amp       = 9'($urandom_range(0, 511));
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      if (out_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check({x.name, "_latency"}, lat, 4);
    check(x.name, int'(out_sample), x.exp);
  endtask

  task automatic burst(input vec_t b[4], input logic [3:0] pv,
                       input int es[4], input string nm);
    logic [3:0] gv;
    int         gs[4];
    gv = '0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j >= 4) begin
        gv[j-4] = out_valid;
        gs[j-4] = int'(out_sample);
      end
      if (j < 4) drive(pv[j], b[j]);
      else in_valid = 1'b0;
    end
    check({nm, "_valid"}, int'(gv), int'(pv));
    for (int j = 0; j < 4; j++) check($sformatf("%s_s%0d", nm, j), gs[j], es[j]);
  endtask

  initial begin
    vec_t vecs[14];
    vec_t b[4];
    int   es[4];

    vecs[0]  = '{32'h0000_0000, 11'h000, 2'd1, 9'd256, 1023, "sq_hi"};
    vecs[1]  = '{32'h8000_0000, 11'h000, 2'd1, 9'd256, 1,    "sq_lo"};
    vecs[2]  = '{32'h0020_0000, 11'h7FF, 2'd1, 9'd256, 1023, "wrap_sq"};
    vecs[3]  = '{32'h0020_0000, 11'h7FF, 2'd3, 9'd256, 1,    "wrap_saw"};
    vecs[4]  = '{32'h0000_0000, 11'h000, 2'd0, 9'd256, 513,  "sin_q0"};
    vecs[5]  = '{32'h4000_0000, 11'h000, 2'd0, 9'd256, 1023, "sin_q1"};
    vecs[6]  = '{32'h8000_0000, 11'h000, 2'd0, 9'd256, 511,  "sin_q2"};
    vecs[7]  = '{32'hC000_0000, 11'h000, 2'd0, 9'd256, 1,    "sin_q3"};
    vecs[8]  = '{32'h7FE0_0000, 11'h000, 2'd2, 9'd128, 767,  "tri_a128"};
    vecs[9]  = '{32'h7FE0_0000, 11'h000, 2'd2, 9'd300, 1023, "tri_a300"};
    vecs[10] = '{32'h7FE0_0000, 11'h000, 2'd2, 9'd0,   512,  "tri_a0"};
    vecs[11] = '{32'h8000_0000, 11'h000, 2'd1, 9'd128, 256,  "sq_lo_a128"};
    vecs[12] = '{32'h0000_0000, 11'h000, 2'd2, 9'd256, 1,    "tri_min"};
    vecs[13] = '{32'hFFE0_0000, 11'h000, 2'd3, 9'd256, 1023, "saw_max"};

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = i[0];
      in_phase = $urandom();
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    for (int j = 0; j < 4; j++) begin
      b[j]  = vecs[4 + j];
      es[j] = vecs[4 + j].exp;
    end
    burst(b, 4'b1111, es, "sin_b2b");

    b[0] = vecs[0];
    b[1] = vecs[1];
    b[2] = '{32'h0000_0000, 11'h000, 2'd3, 9'd256, 1, "saw0"};
    b[3] = vecs[0];
    es   = '{1023, 1023, 1, 1023};
    burst(b, 4'b1101, es, "bubble");

    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      drive(1'b1, vecs[1]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_valid", int'(out_valid), 1);
    check("pre_rst_sample", int'(out_sample), 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_sample", int'(out_sample), 512);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_phase  = $urandom();
      phase_off = 11'($urandom_range(0, 2047));
      wave_sel  = 2'($urandom_range(0, 3));
      amp       = 9'($urandom_range(0, 511));
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, wanted finish");
    $fatal(1, "watchdog");
  end

endmodule
